// File: rtl/ysyx_23060203_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package ysyx_23060203_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;
    typedef enum logic {ARB_IFU, ARB_LSU} arb_master_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // One-hot {lsu,ifu} encoding of a master, as presented on the grant port.
    function automatic logic [1:0] master_onehot(input arb_master_t m);
        return (m == ARB_LSU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_23060203_axi_if.sv
// AXI4 bundle shared by the IFU, LSU and memory sides of the arbiter.
// Modport "in" faces a master (arbiter acts as slave); "out" faces memory.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;
    logic [3:0] bid;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic [3:0]        rid;

    modport in (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rresp, rdata, rlast, rid,
        input  rready
    );

    modport out (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rresp, rdata, rlast, rid,
        output rready
    );

endinterface

// File: rtl/ysyx_23060203_arb_pick.sv
// Read winner selection for the memory arbiter.
// ARB_ROUND_ROBIN_EN defined: alternate on ties, first tie goes to IFU.
// ARB_ROUND_ROBIN_EN undefined: IFU first, LSU forced after STARVE_MAX IFU wins.
module ysyx_23060203_arb_pick
    import ysyx_23060203_arb_pkg::*;
#(
    parameter int STARVE_MAX = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_ifu,
    input  logic        req_lsu,
    input  logic        grant_fire,
    output arb_master_t pick
);

`ifdef ARB_ROUND_ROBIN_EN
    arb_master_t last;

    // On a tie the master that lost last time gets the bus.
    always_comb begin
        pick = ARB_IFU;
        if (req_ifu && req_lsu) pick = (last == ARB_LSU) ? ARB_IFU : ARB_LSU;
        else if (req_lsu)       pick = ARB_LSU;
    end

    // Remember who won the most recent grant.
    always_ff @(posedge clock) begin
        if (!reset)          last <= ARB_LSU;
        else if (grant_fire) last <= pick;
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // IFU wins unless LSU is alone or has waited through STARVE_MAX IFU grants.
    always_comb begin
        pick = ARB_IFU;
        if (req_lsu && (!req_ifu || starve_cnt == STARVE_LIM)) pick = ARB_LSU;
    end

    // Count IFU grants that bypassed a waiting LSU; any LSU grant clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_fire) begin
            if (pick == ARB_LSU) starve_cnt <= '0;
            else if (req_lsu)    starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Shares one AXI memory port between ICache refill (ifu_r) and the LSU.
// AR/R are arbitrated with one read outstanding; LSU AW/W/B pass straight
// through, and LSU loads wait while a store is unacknowledged.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of IFU priority.
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic       clock,
    input  logic       reset,
    axi_if.in          ifu_r,
    axi_if.in          lsu,
    axi_if.out         mem,
    output logic [1:0] grant,
    output logic       rd_busy
);

    arb_state_t  state;
    arb_master_t pick;
    logic        wr_pend;
    logic        req_ifu;
    logic        req_lsu;
    logic        grant_fire;
    logic        own_lsu;
    logic        in_addr;
    logic        in_data;
    logic        aw_fire;
    logic        b_fire;

    logic [ADDR_W-1:0] ar_addr;
    logic [DATA_W-1:0] r_data;

    assign req_ifu    = ifu_r.arvalid;
    assign req_lsu    = lsu.arvalid && !wr_pend;
    assign grant_fire = (state == ARB_IDLE) && (req_ifu || req_lsu);
    assign own_lsu    = grant[1];
    assign in_addr    = (state == ARB_ADDR);
    assign in_data    = (state == ARB_DATA);
    assign rd_busy    = (state != ARB_IDLE);

    ysyx_23060203_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clock      (clock),
        .reset      (reset),
        .req_ifu    (req_ifu),
        .req_lsu    (req_lsu),
        .grant_fire (grant_fire),
        .pick       (pick)
    );

    // Read FSM: sample requests in IDLE, forward AR, then stream R until rlast.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ARB_IDLE;
            grant <= 2'b00;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_fire) begin
                        grant <= master_onehot(pick);
                        state <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (mem.arvalid && mem.arready) state <= ARB_DATA;
                end
                ARB_DATA: begin
                    if (mem.rvalid && mem.rready && mem.rlast) begin
                        state <= ARB_IDLE;
                        grant <= 2'b00;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // AR channel: winner's request goes out unchanged; only the winner sees arready.
    assign ar_addr      = own_lsu ? lsu.araddr : ifu_r.araddr;
    assign mem.araddr   = ar_addr;
    assign mem.arid     = own_lsu ? lsu.arid    : ifu_r.arid;
    assign mem.arlen    = own_lsu ? lsu.arlen   : ifu_r.arlen;
    assign mem.arsize   = own_lsu ? lsu.arsize  : ifu_r.arsize;
    assign mem.arburst  = own_lsu ? lsu.arburst : ifu_r.arburst;
    assign mem.arvalid  = in_addr && (own_lsu ? lsu.arvalid : ifu_r.arvalid);
    assign ifu_r.arready = in_addr && !own_lsu && mem.arready;
    assign lsu.arready   = in_addr &&  own_lsu && mem.arready;

    // R channel: payload broadcast, handshake steered to the winner only.
    assign r_data       = mem.rdata;
    assign ifu_r.rdata  = r_data;
    assign lsu.rdata    = r_data;
    assign ifu_r.rresp  = mem.rresp;
    assign lsu.rresp    = mem.rresp;
    assign ifu_r.rlast  = mem.rlast;
    assign lsu.rlast    = mem.rlast;
    assign ifu_r.rid    = mem.rid;
    assign lsu.rid      = mem.rid;
    assign ifu_r.rvalid = in_data && !own_lsu && mem.rvalid;
    assign lsu.rvalid   = in_data &&  own_lsu && mem.rvalid;
    assign mem.rready   = in_data && (own_lsu ? lsu.rready : ifu_r.rready);

    // LSU write channels are plain wires to memory.
    assign mem.awvalid = lsu.awvalid;
    assign mem.awaddr  = lsu.awaddr;
    assign mem.awid    = lsu.awid;
    assign mem.awlen   = lsu.awlen;
    assign mem.awsize  = lsu.awsize;
    assign mem.awburst = lsu.awburst;
    assign lsu.awready = mem.awready;
    assign mem.wvalid  = lsu.wvalid;
    assign mem.wdata   = lsu.wdata;
    assign mem.wstrb   = lsu.wstrb;
    assign mem.wlast   = lsu.wlast;
    assign lsu.wready  = mem.wready;
    assign lsu.bvalid  = mem.bvalid;
    assign lsu.bresp   = mem.bresp;
    assign lsu.bid     = mem.bid;
    assign mem.bready  = lsu.bready;

    // The ICache never writes: its write channels are parked.
    assign ifu_r.awready = 1'b0;
    assign ifu_r.wready  = 1'b0;
    assign ifu_r.bvalid  = 1'b0;
    assign ifu_r.bresp   = 2'b00;
    assign ifu_r.bid     = 4'd0;

    logic ifu_wr_unused;
    assign ifu_wr_unused = ^{ifu_r.awvalid, ifu_r.awaddr, ifu_r.awid, ifu_r.awlen,
                             ifu_r.awsize, ifu_r.awburst, ifu_r.wvalid, ifu_r.wdata,
                             ifu_r.wstrb, ifu_r.wlast, ifu_r.bready};

    assign aw_fire = mem.awvalid && mem.awready;
    assign b_fire  = mem.bvalid && mem.bready;

    // Store-pending flag; a new AW in the same cycle as a B keeps it set.
    always_ff @(posedge clock) begin
        if (!reset)       wr_pend <= 1'b0;
        else if (aw_fire) wr_pend <= 1'b1;
        else if (b_fire)  wr_pend <= 1'b0;
    end

endmodule

// File: tb/tb_ysyx_23060203_mem_arbiter.sv
// Directed bench for the memory arbiter (default fixed-priority build).
module tb_ysyx_23060203_mem_arbiter;
    import ysyx_23060203_arb_pkg::*;

    logic       clock;
    logic       reset;
    logic [1:0] grant;
    logic       rd_busy;
    int         checks;
    int         errors;

    axi_if ifu_bus ();
    axi_if lsu_bus ();
    axi_if mem_bus ();

    ysyx_23060203_mem_arbiter dut (
        .clock   (clock),
        .reset   (reset),
        .ifu_r   (ifu_bus),
        .lsu     (lsu_bus),
        .mem     (mem_bus),
        .grant   (grant),
        .rd_busy (rd_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic init_bus();
        ifu_bus.awvalid = 0; ifu_bus.awaddr = 0; ifu_bus.awid = 0; ifu_bus.awlen = 0;
        ifu_bus.awsize = 0; ifu_bus.awburst = 0; ifu_bus.wvalid = 0; ifu_bus.wdata = 0;
        ifu_bus.wstrb = 0; ifu_bus.wlast = 0; ifu_bus.bready = 0; ifu_bus.arvalid = 0;
        ifu_bus.araddr = 0; ifu_bus.arid = 0; ifu_bus.arlen = 0; ifu_bus.arsize = 0;
        ifu_bus.arburst = 0; ifu_bus.rready = 0;
        lsu_bus.awvalid = 0; lsu_bus.awaddr = 0; lsu_bus.awid = 0; lsu_bus.awlen = 0;
        lsu_bus.awsize = 0; lsu_bus.awburst = 0; lsu_bus.wvalid = 0; lsu_bus.wdata = 0;
        lsu_bus.wstrb = 0; lsu_bus.wlast = 0; lsu_bus.bready = 0; lsu_bus.arvalid = 0;
        lsu_bus.araddr = 0; lsu_bus.arid = 0; lsu_bus.arlen = 0; lsu_bus.arsize = 0;
        lsu_bus.arburst = 0; lsu_bus.rready = 0;
        mem_bus.awready = 0; mem_bus.wready = 0; mem_bus.bvalid = 0; mem_bus.bresp = 0;
        mem_bus.bid = 0; mem_bus.arready = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0;
        mem_bus.rresp = 0; mem_bus.rlast = 0; mem_bus.rid = 0;
    endtask

    task automatic ifu_ar(input logic [31:0] addr, input logic [7:0] len);
        ifu_bus.araddr = addr; ifu_bus.arlen = len; ifu_bus.arid = 4'h1;
        ifu_bus.arsize = 3'd2; ifu_bus.arburst = AXI_BURST_INCR; ifu_bus.arvalid = 1;
    endtask

    task automatic lsu_ar(input logic [31:0] addr, input logic [7:0] len);
        lsu_bus.araddr = addr; lsu_bus.arlen = len; lsu_bus.arid = 4'h2;
        lsu_bus.arsize = 3'd2; lsu_bus.arburst = AXI_BURST_INCR; lsu_bus.arvalid = 1;
    endtask

    // Memory accepts the winner's AR; optionally the master keeps arvalid up.
    task automatic ar_hs(input bit to_lsu, input bit keep, input string tag);
        mem_bus.arready = 1;
        #1;
        chk({tag, " mem.arvalid"}, mem_bus.arvalid, 1);
        chk({tag, " ifu.arready"}, ifu_bus.arready, !to_lsu);
        chk({tag, " lsu.arready"}, lsu_bus.arready, to_lsu);
        tick();
        mem_bus.arready = 0;
        if (!keep) begin
            if (to_lsu) lsu_bus.arvalid = 0;
            else        ifu_bus.arvalid = 0;
        end
        chk({tag, " rd_busy data"}, rd_busy, 1);
    endtask

    // Memory returns a burst; err_beat gets SLVERR.
    task automatic serve(input bit to_lsu, input int beats, input int err_beat,
                         input logic [31:0] base, input string tag);
        ifu_bus.rready = !to_lsu;
        lsu_bus.rready = to_lsu;
        for (int i = 0; i < beats; i++) begin
            mem_bus.rvalid = 1;
            mem_bus.rdata  = base + i;
            mem_bus.rlast  = (i == beats - 1);
            mem_bus.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            #1;
            if (to_lsu) begin
                chk($sformatf("%s b%0d lsu.rvalid", tag, i), lsu_bus.rvalid, 1);
                chk($sformatf("%s b%0d lsu.rdata", tag, i), lsu_bus.rdata, base + i);
                chk($sformatf("%s b%0d lsu.rlast", tag, i), lsu_bus.rlast, (i == beats - 1));
                chk($sformatf("%s b%0d lsu.rresp", tag, i), lsu_bus.rresp, (i == err_beat) ? 2 : 0);
                chk($sformatf("%s b%0d ifu.rvalid", tag, i), ifu_bus.rvalid, 0);
            end else begin
                chk($sformatf("%s b%0d ifu.rvalid", tag, i), ifu_bus.rvalid, 1);
                chk($sformatf("%s b%0d ifu.rdata", tag, i), ifu_bus.rdata, base + i);
                chk($sformatf("%s b%0d ifu.rlast", tag, i), ifu_bus.rlast, (i == beats - 1));
                chk($sformatf("%s b%0d lsu.rvalid", tag, i), lsu_bus.rvalid, 0);
            end
            chk($sformatf("%s b%0d mem.rready", tag, i), mem_bus.rready, 1);
            chk($sformatf("%s b%0d grant", tag, i), grant, to_lsu ? 2 : 1);
            chk($sformatf("%s b%0d lsu.arready", tag, i), lsu_bus.arready, 0);
            tick();
        end
        mem_bus.rvalid = 0; mem_bus.rlast = 0; mem_bus.rresp = 0;
        ifu_bus.rready = 0; lsu_bus.rready = 0;
        #1;
        chk({tag, " grant end"}, grant, 0);
        chk({tag, " rd_busy end"}, rd_busy, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clock  = 0;
        reset  = 0;
        init_bus();
        tick();
        tick();

        // Reset state
        chk("rst grant", grant, 0);
        chk("rst rd_busy", rd_busy, 0);
        chk("rst wr_pend", dut.wr_pend, 0);
        chk("rst mem.arvalid", mem_bus.arvalid, 0);
        chk("rst ifu.arready", ifu_bus.arready, 0);
        chk("rst ifu.rvalid", ifu_bus.rvalid, 0);
        chk("rst lsu.arready", lsu_bus.arready, 0);
        chk("rst lsu.rvalid", lsu_bus.rvalid, 0);
        reset = 1;
        tick();

        // T1: lone IFU 4-beat burst
        ifu_ar(32'h8000_0000, 8'd3);
        ifu_bus.awvalid = 1;
        #1;
        chk("t1 idle mem.arvalid", mem_bus.arvalid, 0);
        chk("t1 ifu.awready", ifu_bus.awready, 0);
        ifu_bus.awvalid = 0;
        tick();
        chk("t1 grant", grant, 1);
        chk("t1 rd_busy", rd_busy, 1);
        chk("t1 mem.araddr", mem_bus.araddr, 32'h8000_0000);
        chk("t1 mem.arlen", mem_bus.arlen, 3);
        chk("t1 mem.arid", mem_bus.arid, 1);
        chk("t1 ifu.arready wait", ifu_bus.arready, 0);
        ar_hs(0, 0, "t1");
        serve(0, 4, -1, 32'h1000, "t1");

        // T2: simultaneous requests, IFU first then LSU
        ifu_ar(32'h8000_0040, 8'd1);
        lsu_ar(32'h8000_2000, 8'd0);
        tick();
        chk("t2 grant ifu", grant, 1);
        chk("t2 mem.araddr", mem_bus.araddr, 32'h8000_0040);
        ar_hs(0, 0, "t2 ifu");
        serve(0, 2, -1, 32'h2000, "t2 ifu");
        tick();
        chk("t2 grant lsu", grant, 2);
        chk("t2 mem.araddr lsu", mem_bus.araddr, 32'h8000_2000);
        ar_hs(1, 0, "t2 lsu");
        serve(1, 1, -1, 32'h3000, "t2 lsu");

`ifndef ARB_ROUND_ROBIN_EN
        // T3: LSU pending through 15 back-to-back IFU grants
        lsu_ar(32'h8000_3000, 8'd0);
        ifu_ar(32'h8000_0080, 8'd0);
        for (int g = 0; g < 15; g++) begin
            tick();
            chk($sformatf("t3 grant %0d", g), grant, 1);
            ar_hs(0, 1, $sformatf("t3 g%0d", g));
            serve(0, 1, -1, 32'h4000 + g, $sformatf("t3 g%0d", g));
        end
        tick();
        chk("t3 grant lsu", grant, 2);
        ifu_bus.arvalid = 0;
        ar_hs(1, 0, "t3 lsu");
        serve(1, 1, -1, 32'h5000, "t3 lsu");
`endif

        // T4: LSU load held behind outstanding store
        lsu_bus.awaddr = 32'ha000_0000; lsu_bus.awlen = 0; lsu_bus.awvalid = 1;
        mem_bus.awready = 1;
        #1;
        chk("t4 mem.awvalid", mem_bus.awvalid, 1);
        chk("t4 mem.awaddr", mem_bus.awaddr, 32'ha000_0000);
        chk("t4 lsu.awready", lsu_bus.awready, 1);
        tick();
        lsu_bus.awvalid = 0; mem_bus.awready = 0;
        chk("t4 wr_pend set", dut.wr_pend, 1);
        lsu_bus.wdata = 32'hdead_beef; lsu_bus.wstrb = 4'hf; lsu_bus.wlast = 1;
        lsu_bus.wvalid = 1; mem_bus.wready = 1;
        #1;
        chk("t4 mem.wdata", mem_bus.wdata, 32'hdead_beef);
        chk("t4 lsu.wready", lsu_bus.wready, 1);
        tick();
        lsu_bus.wvalid = 0; mem_bus.wready = 0;
        lsu_ar(32'ha000_0000, 8'd0);
        tick();
        chk("t4 lsu blocked 1", grant, 0);
        tick();
        chk("t4 lsu blocked 2", grant, 0);
        ifu_ar(32'h8000_0100, 8'd0);
        tick();
        chk("t4 ifu granted", grant, 1);
        ar_hs(0, 0, "t4 ifu");
        serve(0, 1, -1, 32'h6000, "t4 ifu");
        tick();
        chk("t4 lsu still blocked", grant, 0);
        // B and a second AW in the same cycle: flag stays set
        mem_bus.bvalid = 1; lsu_bus.bready = 1;
        lsu_bus.awvalid = 1; mem_bus.awready = 1;
        #1;
        chk("t4 lsu.bvalid", lsu_bus.bvalid, 1);
        tick();
        lsu_bus.awvalid = 0; mem_bus.awready = 0;
        chk("t4 wr_pend set+clr", dut.wr_pend, 1);
        chk("t4 lsu blocked 3", grant, 0);
        tick();
        mem_bus.bvalid = 0; lsu_bus.bready = 0;
        chk("t4 wr_pend clr", dut.wr_pend, 0);
        chk("t4 lsu blocked at B", grant, 0);
        tick();
        chk("t4 lsu granted", grant, 2);
        chk("t4 mem.araddr", mem_bus.araddr, 32'ha000_0000);
        ar_hs(1, 0, "t4 lsu");
        serve(1, 1, -1, 32'h7000, "t4 lsu");

        // T5: SLVERR on beat 2 of a 4-beat LSU burst
        lsu_ar(32'h8000_4000, 8'd3);
        tick();
        chk("t5 grant", grant, 2);
        ar_hs(1, 0, "t5");
        serve(1, 4, 1, 32'h8000, "t5");

        // T6: reset during DATA beat 1
        lsu_bus.awvalid = 1; mem_bus.awready = 1;
        tick();
        lsu_bus.awvalid = 0; mem_bus.awready = 0;
        chk("t6 wr_pend pre", dut.wr_pend, 1);
        ifu_ar(32'h8000_0180, 8'd3);
        tick();
        chk("t6 grant", grant, 1);
        ar_hs(0, 0, "t6");
        ifu_bus.rready = 1; mem_bus.rvalid = 1; mem_bus.rdata = 32'h9000;
        #1;
        chk("t6 ifu.rvalid b0", ifu_bus.rvalid, 1);
        reset = 0;
        tick();
        chk("t6 rst grant", grant, 0);
        chk("t6 rst rd_busy", rd_busy, 0);
        chk("t6 rst wr_pend", dut.wr_pend, 0);
        chk("t6 rst ifu.rvalid", ifu_bus.rvalid, 0);
        mem_bus.rvalid = 0; ifu_bus.rready = 0;
        reset = 1;
        tick();
        ifu_ar(32'h8000_0200, 8'd0);
        tick();
        chk("t6 fresh grant", grant, 1);
        chk("t6 fresh araddr", mem_bus.araddr, 32'h8000_0200);
        ar_hs(0, 0, "t6 fresh");
        serve(0, 1, -1, 32'ha000, "t6 fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
